// File: rtl/ray_tracer_sphere_scan.sv
// Ray/sphere scanner: walks an external object RAM one sphere at a time and
// reports the nearest forward hit (t, index, colour) over a valid/ready handshake.
module ray_tracer_sphere_scan #(
   parameter int XY_W    = 10,
   parameter int Z_W     = 8,
   parameter int R_W     = 8,
   parameter int COLOR_W = 12,
   parameter int N_OBJ   = 8,
   parameter int T_W     = 10,
   parameter int ACC_W   = 48,
   parameter int IDX_W   = ($clog2(N_OBJ) > 1) ? $clog2(N_OBJ) : 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                ray_valid,
   output logic                                ray_ready,
   input  logic [2*XY_W+Z_W-1:0]               ray_init,
   input  logic [2*XY_W+Z_W+2:0]               ray_dir,
   input  logic [IDX_W:0]                      obj_count,
   output logic [IDX_W-1:0]                    obj_addr,
   output logic                                obj_rd,
   input  logic [COLOR_W+R_W+2*XY_W+Z_W-1:0]   obj_data,
   output logic                                res_valid,
   input  logic                                res_ready,
   output logic [T_W-1:0]                      res_t,
   output logic [IDX_W-1:0]                    res_idx,
   output logic [COLOR_W-1:0]                  res_color,
   output logic                                res_hit
);

   localparam int P_W      = 2*XY_W + Z_W;
   localparam int D_W      = P_W + 3;
   localparam int O_W      = COLOR_W + R_W + P_W;
   localparam int SQ_N     = ACC_W / 2;
   localparam int STEP_MAX = (SQ_N > T_W) ? SQ_N : T_W;
   localparam int CNT_W    = $clog2(STEP_MAX + 1);
   localparam logic [T_W-1:0] T_MISS = '1;

   typedef enum logic [3:0] {
      IDLE, FETCH, LOAD, DOT, DISC, SQRT, DIV, CMP, NEXT, DONE
   } state_t;

   state_t state, state_nxt;

   logic [P_W-1:0]            init_q;
   logic [D_W-1:0]            dir_q;
   logic [O_W-1:0]            obj_q;
   logic [IDX_W:0]            count_q, idx_q, count_clamp;
   logic [CNT_W-1:0]          cnt, div_bit;
   logic signed [ACC_W-1:0]   dp_q, dd_q, pp_q, rr_q;
   logic [ACC_W-1:0]          sq_x, sq_rem, rem_sh, trial_sq;
   logic [SQ_N-1:0]           sq_root;
   logic                      sq_ge;
   logic signed [ACC_W-1:0]   div_rem, div_in, div_try, num, lim, disc;
   logic                      div_ok, div_miss;
   logic [T_W-1:0]            quo, best_t;
   logic [IDX_W-1:0]          best_idx;
   logic [COLOR_W-1:0]        best_color;
   logic                      best_hit;

   logic [XY_W-1:0]           ex, ey, cx, cy;
   logic [Z_W-1:0]            ez, cz;
   logic [R_W-1:0]            r;
   logic [COLOR_W-1:0]        color;
   logic signed [XY_W:0]      dx, dy;
   logic signed [Z_W:0]       dz;
   logic signed [ACC_W-1:0]   px, py, pz, dxe, dye, dze, re;
   logic signed [ACC_W-1:0]   dot_dp, dot_dd, dot_pp, dot_rr;

   assign {ex, ey, ez}             = init_q;
   assign {dx, dy, dz}             = dir_q;
   assign {color, r, cx, cy, cz}   = obj_q;

   assign px  = $signed(ACC_W'(ex)) - $signed(ACC_W'(cx));
   assign py  = $signed(ACC_W'(ey)) - $signed(ACC_W'(cy));
   assign pz  = $signed(ACC_W'(ez)) - $signed(ACC_W'(cz));
   assign dxe = ACC_W'(dx);
   assign dye = ACC_W'(dy);
   assign dze = ACC_W'(dz);
   assign re  = $signed(ACC_W'(r));

   assign dot_dp = dxe*px + dye*py + dze*pz;
   assign dot_dd = dxe*dxe + dye*dye + dze*dze;
   assign dot_pp = px*px + py*py + pz*pz;
   assign dot_rr = re*re;
   assign disc   = dp_q*dp_q - dd_q*(pp_q - rr_q);

   // Digit-by-digit root: two radicand bits enter per cycle, MSB pair first.
   assign rem_sh   = (sq_rem << 2) | ACC_W'(sq_x[ACC_W-1 -: 2]);
   assign trial_sq = ACC_W'({sq_root, 2'b01});
   assign sq_ge    = (rem_sh >= trial_sq);

   assign num      = -dp_q - $signed(ACC_W'(sq_root));
   assign lim      = dd_q * $signed(ACC_W'(T_MISS));
   assign div_miss = num[ACC_W-1] || (num >= lim);

   // Quotient bits come MSB first by trial-subtracting dd shifted to each weight.
   assign div_bit  = CNT_W'(T_W-1) - cnt;
   assign div_in   = (cnt == '0) ? num : div_rem;
   assign div_try  = div_in - (dd_q <<< div_bit);
   assign div_ok   = !div_try[ACC_W-1];

   assign count_clamp = (obj_count > (IDX_W+1)'(N_OBJ)) ? (IDX_W+1)'(N_OBJ) : obj_count;

   assign ray_ready = (state == IDLE);
   assign res_valid = (state == DONE);
   assign obj_rd    = (state == FETCH);
   assign obj_addr  = (state == FETCH) ? idx_q[IDX_W-1:0] : '0;
   assign res_t     = best_t;
   assign res_idx   = best_idx;
   assign res_color = best_color;
   assign res_hit   = best_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (ray_valid) state_nxt = (count_clamp == '0) ? DONE : FETCH;
         FETCH: state_nxt = LOAD;
         LOAD:  state_nxt = DOT;
         DOT:   state_nxt = DISC;
         DISC:  state_nxt = (disc[ACC_W-1] || dd_q == '0) ? NEXT : SQRT;
         SQRT:  if (cnt == CNT_W'(SQ_N-1)) state_nxt = DIV;
         DIV: begin
            if (cnt == '0 && div_miss)       state_nxt = NEXT;
            else if (cnt == CNT_W'(T_W-1))   state_nxt = CMP;
         end
         CMP:   state_nxt = NEXT;
         NEXT:  state_nxt = (idx_q + 1'b1 == count_q) ? DONE : FETCH;
         DONE:  if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shared step counter restarts on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  cnt <= '0;
      else if (state_nxt != state) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q     <= '0;
         dir_q      <= '0;
         obj_q      <= '0;
         count_q    <= '0;
         idx_q      <= '0;
         dp_q       <= '0;
         dd_q       <= '0;
         pp_q       <= '0;
         rr_q       <= '0;
         sq_x       <= '0;
         sq_rem     <= '0;
         sq_root    <= '0;
         div_rem    <= '0;
         quo        <= '0;
         best_t     <= T_MISS;
         best_idx   <= '0;
         best_color <= '0;
         best_hit   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (ray_valid) begin
               init_q     <= ray_init;
               dir_q      <= ray_dir;
               count_q    <= count_clamp;
               idx_q      <= '0;
               best_t     <= T_MISS;
               best_idx   <= '0;
               best_color <= '0;
               best_hit   <= 1'b0;
            end
            LOAD: obj_q <= obj_data;
            DOT: begin
               dp_q <= dot_dp;
               dd_q <= dot_dd;
               pp_q <= dot_pp;
               rr_q <= dot_rr;
            end
            DISC: begin
               sq_x    <= disc;
               sq_rem  <= '0;
               sq_root <= '0;
            end
            SQRT: begin
               sq_x    <= sq_x << 2;
               sq_rem  <= sq_ge ? rem_sh - trial_sq : rem_sh;
               sq_root <= {sq_root[SQ_N-2:0], sq_ge};
            end
            DIV: begin
               div_rem <= div_ok ? div_try : div_in;
               quo     <= {quo[T_W-2:0], div_ok};
            end
            CMP: if (quo < best_t) begin
               best_t     <= quo;
               best_idx   <= idx_q[IDX_W-1:0];
               best_color <= color;
               best_hit   <= 1'b1;
            end
            NEXT: idx_q <= idx_q + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ray_tracer_sphere_scan.sv
// Directed bench for ray_tracer_sphere_scan: scene RAM model, expected results
// queued per ray and checked (value and latency) when res_valid appears.
module tb_ray_tracer_sphere_scan;

   localparam int XY_W    = 10;
   localparam int Z_W     = 8;
   localparam int R_W     = 8;
   localparam int COLOR_W = 12;
   localparam int N_OBJ   = 8;
   localparam int T_W     = 10;
   localparam int ACC_W   = 48;
   localparam int IDX_W   = 3;
   localparam int P_W     = 2*XY_W + Z_W;
   localparam int D_W     = P_W + 3;
   localparam int O_W     = COLOR_W + R_W + P_W;
   localparam int MISS    = 'h3FF;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                ray_valid, ray_ready;
   logic [P_W-1:0]      ray_init;
   logic [D_W-1:0]      ray_dir;
   logic [IDX_W:0]      obj_count;
   logic [IDX_W-1:0]    obj_addr;
   logic                obj_rd;
   logic [O_W-1:0]      obj_data = '0;
   logic                res_valid, res_ready;
   logic [T_W-1:0]      res_t;
   logic [IDX_W-1:0]    res_idx;
   logic [COLOR_W-1:0]  res_color;
   logic                res_hit;

   logic [O_W-1:0]      mem [0:N_OBJ-1];

   typedef struct {
      logic [T_W-1:0]     t;
      logic [IDX_W-1:0]   idx;
      logic [COLOR_W-1:0] color;
      logic               hit;
      int                 lat;
   } exp_t;
   exp_t sb[$];

   int n_assert = 0;
   int n_fail   = 0;
   bit seen;

   ray_tracer_sphere_scan #(
      .XY_W(XY_W), .Z_W(Z_W), .R_W(R_W), .COLOR_W(COLOR_W),
      .N_OBJ(N_OBJ), .T_W(T_W), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ray_valid(ray_valid), .ray_ready(ray_ready),
      .ray_init(ray_init), .ray_dir(ray_dir), .obj_count(obj_count),
      .obj_addr(obj_addr), .obj_rd(obj_rd), .obj_data(obj_data),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_t(res_t), .res_idx(res_idx), .res_color(res_color), .res_hit(res_hit)
   );

   always #5 clk = ~clk;

   // Synchronous object RAM: one-cycle read latency.
   always @(posedge clk) if (obj_rd) obj_data <= mem[obj_addr];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [O_W-1:0] obj(input int col, input int rad, input int x, input int y, input int z);
      return {COLOR_W'(col), R_W'(rad), XY_W'(x), XY_W'(y), Z_W'(z)};
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "/ray_ready"}, ray_ready, 1);
      check({tag, "/res_valid"}, res_valid, 0);
      check({tag, "/obj_rd"},    obj_rd,    0);
      check({tag, "/obj_addr"},  obj_addr,  0);
      check({tag, "/res_t"},     res_t,     MISS);
      check({tag, "/res_idx"},   res_idx,   0);
      check({tag, "/res_color"}, res_color, 0);
      check({tag, "/res_hit"},   res_hit,   0);
   endtask

   task automatic drive_ray(input int ex, input int ey, input int ez,
                            input int dx, input int dy, input int dz, input int cnt);
      ray_init  = {XY_W'(ex), XY_W'(ey), Z_W'(ez)};
      ray_dir   = {(XY_W+1)'(dx), (XY_W+1)'(dy), (Z_W+1)'(dz)};
      obj_count = (IDX_W+1)'(cnt);
      ray_valid = 1'b1;
   endtask

   task automatic run_ray(input string tag,
                          input int ex, input int ey, input int ez,
                          input int dx, input int dy, input int dz, input int cnt,
                          input int t, input int idx, input int col, input int hit,
                          input int lat, input int hold);
      exp_t e;
      int   n;
      e.t = T_W'(t); e.idx = IDX_W'(idx); e.color = COLOR_W'(col); e.hit = hit[0]; e.lat = lat;
      sb.push_back(e);
      @(negedge clk);
      check({tag, "/ray_ready"}, ray_ready, 1);
      drive_ray(ex, ey, ez, dx, dy, dz, cnt);
      @(negedge clk);
      ray_valid = 1'b0;
      n = 1;
      while (!res_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      check({tag, "/valid"},   res_valid, 1);
      check({tag, "/latency"}, n,         e.lat);
      check({tag, "/t"},       res_t,     e.t);
      check({tag, "/idx"},     res_idx,   e.idx);
      check({tag, "/color"},   res_color, e.color);
      check({tag, "/hit"},     res_hit,   e.hit);
      for (int i = 0; i < hold; i++) begin
         ray_valid = 1'b1;
         @(negedge clk);
         check({tag, "/hold_valid"}, res_valid, 1);
         check({tag, "/hold_ready"}, ray_ready, 0);
         check({tag, "/hold_t"},     res_t,     e.t);
         check({tag, "/hold_idx"},   res_idx,   e.idx);
         check({tag, "/hold_color"}, res_color, e.color);
      end
      ray_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({tag, "/released"}, res_valid, 0);
      check({tag, "/idle"},     ray_ready, 1);
   endtask

   initial begin
      ray_valid = 1'b0;
      res_ready = 1'b0;
      ray_init  = '0;
      ray_dir   = '0;
      obj_count = '0;
      for (int i = 0; i < N_OBJ; i++) mem[i] = '0;

      repeat (2) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      mem[0] = obj('hABC, 10, 200, 100, 50);
      run_ray("single_hit", 100, 100, 50, 1, 0, 0, 1, 90, 0, 'hABC, 1, 41, 10);

      mem[1] = obj('h123, 5, 150, 100, 50);
      run_ray("nearest_of_2", 100, 100, 50, 1, 0, 0, 2, 45, 1, 'h123, 1, 81, 0);

      mem[2] = obj('h456, 5, 150, 100, 50);
      run_ray("tie", 100, 100, 50, 1, 0, 0, 3, 45, 1, 'h123, 1, 121, 0);

      mem[0] = obj('h111, 10, 200, 150, 50);
      run_ray("disc_neg", 100, 100, 50, 1, 0, 0, 1, MISS, 0, 0, 0, 6, 0);

      mem[0] = obj('h222, 10, 50, 100, 50);
      run_ray("behind", 100, 100, 50, 1, 0, 0, 1, MISS, 0, 0, 0, 31, 0);

      mem[0] = obj('h333, 10, 105, 100, 50);
      run_ray("inside", 100, 100, 50, 1, 0, 0, 1, MISS, 0, 0, 0, 31, 0);

      mem[0] = obj('hABC, 10, 200, 100, 50);
      run_ray("zero_dir", 100, 100, 50, 0, 0, 0, 1, MISS, 0, 0, 0, 6, 0);
      run_ray("dir_x2", 100, 100, 50, 2, 0, 0, 1, 45, 0, 'hABC, 1, 41, 0);
      run_ray("neg_dir", 300, 100, 50, -1, 0, 0, 1, 90, 0, 'hABC, 1, 41, 0);

      mem[0] = obj('h777, 1, 1023, 100, 50);
      run_ray("range_1022", 0, 100, 50, 1, 0, 0, 1, 1022, 0, 'h777, 1, 41, 0);
      mem[0] = obj('h777, 0, 1023, 100, 50);
      run_ray("range_limit", 0, 100, 50, 1, 0, 0, 1, MISS, 0, 0, 0, 31, 0);

      run_ray("count_zero", 100, 100, 50, 1, 0, 0, 0, MISS, 0, 0, 0, 1, 0);

      for (int i = 0; i < N_OBJ; i++) mem[i] = obj('h111, 10, 200, 150, 50);
      mem[5] = obj('h5A5, 10, 200, 100, 50);
      run_ray("count_clamp", 100, 100, 50, 1, 0, 0, 15, 90, 5, 'h5A5, 1, 76, 0);

      // Abort during the second object's square root, after object 0 has hit.
      mem[0] = obj('hABC, 10, 200, 100, 50);
      mem[1] = obj('h123, 5, 150, 100, 50);
      @(negedge clk);
      drive_ray(100, 100, 50, 1, 0, 0, 2);
      @(negedge clk);
      ray_valid = 1'b0;
      repeat (54) @(negedge clk);
      check("mid_scan/hit_before_reset", res_hit, 1);
      check("mid_scan/t_before_reset",   res_t,   90);
      #2 rst_n = 1'b0;
      #1 check_reset("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (res_valid) seen = 1'b1;
      end
      check("mid_reset/no_result", seen, 0);
      run_ray("after_reset", 100, 100, 50, 1, 0, 0, 2, 45, 1, 'h123, 1, 81, 0);

      check("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
